// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts WAIT cycles of a read; flags expiry on the TIMEOUT-th cycle without response.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q is 0 in the first WAIT cycle, so this marks the TIMEOUT-th one.
  assign expired_o = active_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bank between IF fetches and MEM loads/stores, MEM first.
// Define MEM_ARB_TIMEOUT_EN to abort reads stuck in WAIT after TIMEOUT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              timeout_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              wd_expired;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          owner_d = OWN_MEM;
          we_d    = mem_wr;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          state_d = ISSUE;
        end else if (if_req) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid || wd_expired) begin
          // A watchdog abort hands the requester a NOP instead of bus data.
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus_rvalid ? bus_rdata : DATA_W'(NOP_INSTR);
          end else begin
            mem_rdata_d = bus_rvalid ? bus_rdata : DATA_W'(NOP_INSTR);
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_req   = (state_q == ISSUE);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = (state_q == DONE) && (owner_q == OWN_IF);
  assign mem_done  = (state_q == DONE) && (owner_q == OWN_MEM);
  assign if_stall  = if_req && !if_done;
  assign mem_stall = (mem_rd || mem_wr) && !mem_done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_start;
  logic timeout_err_q;

  assign wd_start = (state_q == ISSUE) && bus_gnt && !we_q;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .start_i  (wd_start),
    .active_i (state_q == WAIT),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else if (wd_expired && !bus_rvalid) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done, if_stall;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        timeout_err;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_mem_rdata = '0;

  typedef struct {
    bit          is_mem;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          g;     // ISSUE cycles until grant (inclusive)
    int          w;     // WAIT cycles until rvalid (inclusive)
    logic [31:0] rdata;
    int          lat;   // cycles from request to done pulse
  } vec_t;

  vec_t vt[5];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic release_req(input bit own_mem);
    if (own_mem) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end else begin
      if_req = 1'b0;
    end
  endtask

  // Acts as both the requester and the memory; called at the negedge of an IDLE cycle
  // with the request already driven. Expects the done pulse exactly `lat` cycles later.
  task automatic serve(input bit own_mem, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int g, input int w,
                       input logic [31:0] rdata, input int lat, input bit stray, input bit drop);
    int iss = 0;
    int wcnt = 0;
    bit granted = 1'b0;
    bit done_exp;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      done_exp = (cyc == lat);
      check1("if_done", if_done, done_exp && !own_mem);
      check1("mem_done", mem_done, done_exp && own_mem);
      check1("if_stall", if_stall, if_req && !(done_exp && !own_mem));
      check1("mem_stall", mem_stall, (mem_rd || mem_wr) && !(done_exp && own_mem));
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        iss++;
        check32("bus_addr", bus_addr, addr);
        check1("bus_we", bus_we, we);
        if (we) check32("bus_wdata", bus_wdata, wdata);
        if (iss == g) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
        end
        if (stray) bus_rvalid = 1'($urandom_range(0, 1));
      end else if (granted && !we && !done_exp) begin
        wcnt++;
        if (wcnt == w) begin
          bus_rvalid = 1'b1;
          bus_rdata = rdata;
        end
      end
      if (done_exp) begin
        if (!we) begin
          if (own_mem) exp_mem_rdata = rdata;
          else         exp_if_rdata = rdata;
        end
        check32("if_rdata", if_rdata, exp_if_rdata);
        check32("mem_rdata", mem_rdata, exp_mem_rdata);
        release_req(own_mem);
      end else if (drop && cyc == 1) begin
        release_req(own_mem);
      end
    end
    check32("bus_req_cycles", 32'(iss), 32'(g));
  endtask

  // The cycle after a done pulse must be an idle bubble with nothing issued.
  task automatic bubble(input bit stray);
    @(posedge clk);
    @(negedge clk);
    check1("bubble_bus_req", bus_req, 1'b0);
    check1("bubble_if_done", if_done, 1'b0);
    check1("bubble_mem_done", mem_done, 1'b0);
    bus_rvalid = stray;
    bus_rdata = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run did not finish, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    bit own_mem, we, stray, drop;
    int kind, g, w, lat;
    logic [31:0] a, d, r;

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         1, 1, 32'h2008_0005, 3};
    vt[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4, 1, 32'h0,         5};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         2, 3, 32'h1122_3344, 6};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 1, 1, 32'h0,         2};
    vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0,         3, 2, 32'h00A0_0093, 6};

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_bus_req", bus_req, 1'b0);
    check1("rst_bus_we", bus_we, 1'b0);
    check1("rst_if_done", if_done, 1'b0);
    check1("rst_mem_done", mem_done, 1'b0);
    check1("rst_timeout_err", timeout_err, 1'b0);
    check32("rst_bus_addr", bus_addr, 32'h0);
    check32("rst_bus_wdata", bus_wdata, 32'h0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_mem_rdata", mem_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      v = vt[i];
      if (v.is_mem) begin
        mem_rd = v.rd;
        mem_wr = v.wr;
        mem_addr = v.addr;
        mem_wdata = v.wdata;
      end else begin
        if_req = 1'b1;
        if_addr = v.addr;
      end
      serve(v.is_mem, v.is_mem && v.wr, v.addr, v.wdata, v.g, v.w, v.rdata, v.lat, 1'b0, 1'b0);
      bubble(1'b0);
    end

    // Contention: MEM wins, IF waits out the whole access plus one bubble.
    if_req = 1'b1;
    if_addr = 32'h0000_0500;
    mem_rd = 1'b1;
    mem_addr = 32'h0000_0100;
    serve(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 1, 32'h55AA_55AA, 3, 1'b0, 1'b0);
    bubble(1'b0);
    check1("contend_if_stall_bubble", if_stall, 1'b1);
    serve(1'b0, 1'b0, 32'h0000_0500, 32'h0, 1, 1, 32'h0123_4567, 3, 1'b0, 1'b0);
    bubble(1'b0);

    // Stray rvalid while idle must not disturb anything.
    bus_rvalid = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check1("stray_if_done", if_done, 1'b0);
      check1("stray_mem_done", mem_done, 1'b0);
      check32("stray_if_rdata", if_rdata, exp_if_rdata);
      check32("stray_mem_rdata", mem_rdata, exp_mem_rdata);
    end
    bus_rvalid = 1'b0;

    // Reset arriving while a read sits in WAIT.
    if_req = 1'b1;
    if_addr = 32'h0000_0080;
    @(posedge clk);
    @(negedge clk);
    check1("rstwait_issue", bus_req, 1'b1);
    bus_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_gnt = 1'b0;
    check1("rstwait_in_wait", bus_req, 1'b0);
    #2 reset = 1'b1;
    #1;
    check1("rstwait_bus_req", bus_req, 1'b0);
    check1("rstwait_if_done", if_done, 1'b0);
    check32("rstwait_if_rdata", if_rdata, 32'h0);
    check32("rstwait_mem_rdata", mem_rdata, 32'h0);
    check32("rstwait_bus_addr", bus_addr, 32'h0);
    exp_if_rdata = '0;
    exp_mem_rdata = '0;
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check1("postrst_if_done", if_done, 1'b0);
      check1("postrst_bus_req", bus_req, 1'b0);
      check32("postrst_if_rdata", if_rdata, 32'h0);
    end
    bus_rvalid = 1'b0;

    // Random traffic; expected timing follows from the handshake rules directly.
    for (int n = 0; n < 40; n++) begin
      own_mem = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      g = $urandom_range(1, 4);
      w = $urandom_range(1, 4);
      stray = 1'($urandom_range(0, 1));
      drop = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      r = $urandom;
      if (own_mem) begin
        mem_rd = (kind != 1);
        mem_wr = (kind != 0);
        mem_addr = a;
        mem_wdata = d;
        we = (kind != 0);
      end else begin
        if_req = 1'b1;
        if_addr = a;
        we = 1'b0;
      end
      lat = 1 + g + (we ? 0 : w);
      serve(own_mem, we, a, d, g, w, r, lat, stray, drop);
      bubble(stray);
      bus_rvalid = 1'b0;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    if_req = 1'b1;
    if_addr = 32'h0000_0600;
    serve(1'b0, 1'b0, 32'h0000_0600, 32'h0, 1, 0, 32'h0, 17, 1'b0, 1'b0);
    check1("timeout_err_set", timeout_err, 1'b1);
    bubble(1'b0);
    if_req = 1'b1;
    if_addr = 32'h0000_0604;
    serve(1'b0, 1'b0, 32'h0000_0604, 32'h0, 1, 1, 32'h0000_0013, 3, 1'b0, 1'b0);
    check1("timeout_err_sticky", timeout_err, 1'b1);
    reset = 1'b1;
    #1;
    check1("timeout_err_reset", timeout_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
`else
    check1("timeout_err_tied", timeout_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
